// File: rtl/pc_gen_bp_pkg.sv
// pc_gen_bp_pkg
//   Shared definitions for the predicting fetch PC generator:
//   - reset PC default and the stall-vector bit owned by the PC stage
//   - 2-bit branch counter encodings and saturating step helpers
//   - the BTB entry layout for the default 32-bit / 16-entry geometry
package pc_gen_bp_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          STALL_PC         = 0;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Entry layout for XLEN=32, 16 entries (tag = addr[31:6]).
  // btb_dm derives the same layout from its own parameters so other
  // geometries keep matching widths.
  typedef struct packed {
    logic        valid;
    logic [25:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  // Saturating counter steps: never wrap past ST or below SNT.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'b01;
  endfunction

endpackage

// File: rtl/pc_gen_bp_btb.sv
// btb_dm
//   Direct-mapped branch target buffer with 2-bit counters.
//   Ports:
//     clk, rst        clock, asynchronous active-low reset
//     flush           clear every valid bit (wins over a same-cycle update)
//     lookup_addr     address looked up combinationally
//     lookup_taken    hit and counter predicts taken
//     lookup_target   stored target of the looked-up entry
//     upd_valid       training update strobe
//     upd_pc          PC of the resolved branch/jump
//     upd_taken       resolved direction
//     upd_target      resolved target
module btb_dm
  import pc_gen_bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] lookup_addr,
  output logic            lookup_taken,
  output logic [XLEN-1:0] lookup_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       ctr;
  } entry_t;

  entry_t btb [ENTRIES];

  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  entry_t           lk_entry;
  logic             lk_hit;

  logic [IDX-1:0]   up_idx;
  logic [TAG_W-1:0] up_tag;
  entry_t           up_entry;
  logic             up_hit;

  // Byte offset within a word never selects an entry.
  logic unused_offset;
  assign unused_offset = ^{lookup_addr[1:0], upd_pc[1:0]};

  assign lk_idx        = lookup_addr[IDX+1:2];
  assign lk_tag        = lookup_addr[XLEN-1:IDX+2];
  assign lk_entry      = btb[lk_idx];
  assign lk_hit        = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign lookup_taken  = lk_hit && lk_entry.ctr[1];
  assign lookup_target = lk_entry.target;

  assign up_idx   = upd_pc[IDX+1:2];
  assign up_tag   = upd_pc[XLEN-1:IDX+2];
  assign up_entry = btb[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

  // No bypass: lookups read the registered array, so a training write
  // becomes visible one cycle later. A miss that was not taken is ignored
  // so cold not-taken branches never evict useful entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i].valid  <= 1'b0;
        btb[i].tag    <= '0;
        btb[i].target <= '0;
        btb[i].ctr    <= WNT;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i].valid <= 1'b0;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          btb[up_idx].ctr    <= ctr_inc(up_entry.ctr);
          btb[up_idx].target <= upd_target;
        end else begin
          btb[up_idx].ctr <= ctr_dec(up_entry.ctr);
        end
      end else if (upd_taken) begin
        btb[up_idx].valid  <= 1'b1;
        btb[up_idx].tag    <= up_tag;
        btb[up_idx].target <= upd_target;
        btb[up_idx].ctr    <= WT;
      end
    end
  end

endmodule

// File: rtl/pc_gen_bp.sv
// pc_gen_bp
//   Fetch PC register with BTB-based next-PC prediction.
//   Ports:
//     clk, rst        clock, asynchronous active-low reset
//     jump_flag       resolved redirect from execute (overrides stall)
//     branch_to       redirect target
//     stall_signal    pipeline stall vector, bit STALL_PC holds the PC
//     bp_flush        invalidate all BTB entries
//     upd_*           BTB training from execute
//     pc              registered fetch address
//     predicted_pc    predicted successor of pc
//     pred_taken      predicted_pc came from a taken BTB hit
module pc_gen_bp
  import pc_gen_bp_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEFAULT),
  parameter int              BTB_ENTRIES = 16,
  parameter int              STALL_W     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jump_flag,
  input  logic [XLEN-1:0]    branch_to,
  input  logic [STALL_W-1:0] stall_signal,
  input  logic               bp_flush,
  input  logic               upd_valid,
  input  logic [XLEN-1:0]    upd_pc,
  input  logic               upd_taken,
  input  logic [XLEN-1:0]    upd_target,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    predicted_pc,
  output logic               pred_taken
);

  logic [XLEN-1:0] pc_plus4;
  logic            btb_taken;
  logic [XLEN-1:0] btb_target;

  // Only the PC-stage bit of the stall vector matters here.
  logic unused_stall;
  assign unused_stall = ^stall_signal;

  btb_dm #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .flush         (bp_flush),
    .lookup_addr   (pc),
    .lookup_taken  (btb_taken),
    .lookup_target (btb_target),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target)
  );

  // Sequential fallthrough wraps modulo 2^XLEN.
  assign pc_plus4     = pc + XLEN'(4);
  assign pred_taken   = btb_taken;
  assign predicted_pc = btb_taken ? btb_target : pc_plus4;

  // A resolved redirect must win over a stall, otherwise a stalled
  // front end would lose the mispredict recovery.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (jump_flag) begin
      pc <= branch_to;
    end else if (!stall_signal[STALL_PC]) begin
      pc <= predicted_pc;
    end
  end

endmodule

// File: tb/tb_pc_gen_bp.sv
// tb_pc_gen_bp
//   Directed self-checking bench for pc_gen_bp (XLEN=32, 16 BTB entries).
module tb_pc_gen_bp;

  logic        clk;
  logic        rst;
  logic        jump_flag;
  logic [31:0] branch_to;
  logic [4:0]  stall_signal;
  logic        bp_flush;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] pc;
  logic [31:0] predicted_pc;
  logic        pred_taken;

  int assertCount = 0;
  int failCount   = 0;

  pc_gen_bp #(
    .XLEN        (32),
    .RESET_PC    (32'h0000_0000),
    .BTB_ENTRIES (16),
    .STALL_W     (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag    (jump_flag),
    .branch_to    (branch_to),
    .stall_signal (stall_signal),
    .bp_flush     (bp_flush),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .pc           (pc),
    .predicted_pc (predicted_pc),
    .pred_taken   (pred_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every input for the coming clock edge.
  task automatic applyStimulus(input logic jf, input logic [31:0] bt, input logic st,
                               input logic fl, input logic uv, input logic [31:0] up,
                               input logic ut, input logic [31:0] utg);
    jump_flag    = jf;
    branch_to    = bt;
    stall_signal = {4'b0000, st};
    bp_flush     = fl;
    upd_valid    = uv;
    upd_pc       = up;
    upd_taken    = ut;
    upd_target   = utg;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock and move just past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_pred", predicted_pc, 32'h4);
    checkOutput("reset_taken", {31'b0, pred_taken}, 32'h0);
    #6 rst = 1'b1;
    checkOutput("release_pc", pc, 32'h0);

    // Free-running sequential fetch.
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("free_pc", pc, 32'(4 * i));
      checkOutput("free_taken", {31'b0, pred_taken}, 32'h0);
    end

    // Redirect to 8, then stall there.
    applyStimulus(1, 32'h8, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("redirect_pc", pc, 32'h8);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_hold_pc", pc, 32'h8);
    end
    applyStimulus(1, 32'h100, 1, 0, 0, 0, 0, 0);
    tick();
    checkOutput("jump_over_stall", pc, 32'h100);

    // Allocate 0x10 -> 0x80 while stalled.
    applyStimulus(0, 0, 1, 0, 1, 32'h10, 1, 32'h80);
    tick();
    checkOutput("alloc_stall_pc", pc, 32'h100);
    applyStimulus(1, 32'h10, 1, 0, 0, 0, 0, 0);
    tick();
    checkOutput("hit_pc", pc, 32'h10);
    checkOutput("hit_taken", {31'b0, pred_taken}, 32'h1);
    checkOutput("hit_pred", predicted_pc, 32'h80);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("follow_pred_pc", pc, 32'h80);
    checkOutput("follow_taken", {31'b0, pred_taken}, 32'h0);

    // Counter hysteresis, pc held at 0x10. WT -> ST.
    applyStimulus(1, 32'h10, 1, 0, 1, 32'h10, 1, 32'h80);
    tick();
    checkOutput("st_pc", pc, 32'h10);
    checkOutput("st_pred", predicted_pc, 32'h80);
    // ST -> WT; lookup in the update cycle still sees the old entry.
    applyStimulus(0, 0, 1, 0, 1, 32'h10, 0, 32'h0);
    #1;
    checkOutput("nobypass_pred", predicted_pc, 32'h80);
    tick();
    checkOutput("wt_pred", predicted_pc, 32'h80);
    checkOutput("wt_taken", {31'b0, pred_taken}, 32'h1);
    tick();
    checkOutput("wnt_pred", predicted_pc, 32'h14);
    checkOutput("wnt_taken", {31'b0, pred_taken}, 32'h0);
    tick();
    checkOutput("snt_pred", predicted_pc, 32'h14);
    tick();
    checkOutput("snt_sat_pred", predicted_pc, 32'h14);
    checkOutput("snt_sat_taken", {31'b0, pred_taken}, 32'h0);
    // SNT -> WNT -> WT proves the floor held at SNT; target retrained.
    applyStimulus(0, 0, 1, 0, 1, 32'h10, 1, 32'h90);
    tick();
    checkOutput("snt_up_pred", predicted_pc, 32'h14);
    tick();
    checkOutput("retarget_pred", predicted_pc, 32'h90);
    checkOutput("retarget_pc", pc, 32'h10);

    // Alias: 0x50 shares index 4 with 0x10 and replaces it.
    applyStimulus(0, 0, 1, 0, 1, 32'h50, 1, 32'hC0);
    tick();
    checkOutput("alias_evict_pred", predicted_pc, 32'h14);
    checkOutput("alias_evict_taken", {31'b0, pred_taken}, 32'h0);
    applyStimulus(0, 0, 1, 0, 1, 32'h90, 0, 32'h400);
    tick();
    applyStimulus(1, 32'h50, 1, 0, 0, 0, 0, 0);
    tick();
    checkOutput("alias_hit_pc", pc, 32'h50);
    checkOutput("alias_hit_pred", predicted_pc, 32'hC0);
    checkOutput("alias_hit_taken", {31'b0, pred_taken}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("alias_follow_pc", pc, 32'hC0);

    // Flush beats a simultaneous allocation and leaves pc alone.
    applyStimulus(0, 0, 0, 1, 1, 32'h20, 1, 32'h200);
    tick();
    checkOutput("flush_pc", pc, 32'hC4);
    applyStimulus(1, 32'h50, 1, 0, 0, 0, 0, 0);
    tick();
    checkOutput("flush_miss_50", predicted_pc, 32'h54);
    checkOutput("flush_miss_50_taken", {31'b0, pred_taken}, 32'h0);
    applyStimulus(1, 32'h20, 1, 0, 0, 0, 0, 0);
    tick();
    checkOutput("flush_noalloc_20", predicted_pc, 32'h24);

    // pc+4 wraps to zero.
    applyStimulus(1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0);
    tick();
    checkOutput("wrap_pred", predicted_pc, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("wrap_pc", pc, 32'h0);

    // Asynchronous reset mid-cycle at pc=0x80 with a live entry.
    applyStimulus(1, 32'h80, 1, 0, 1, 32'h80, 1, 32'h300);
    tick();
    checkOutput("prereset_pc", pc, 32'h80);
    checkOutput("prereset_pred", predicted_pc, 32'h300);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset_pc", pc, 32'h0);
    checkOutput("async_reset_pred", predicted_pc, 32'h4);
    checkOutput("async_reset_taken", {31'b0, pred_taken}, 32'h0);
    #2 rst = 1'b1;
    applyStimulus(1, 32'h80, 1, 0, 0, 0, 0, 0);
    tick();
    checkOutput("postreset_pc", pc, 32'h80);
    checkOutput("postreset_pred", predicted_pc, 32'h84);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
